// File: rtl/nn_stream_driver.sv
// nn_stream_driver: packs input words into frames for the network top,
// captures results in a credit-guarded FIFO and serialises them out.
// Ports:
//   ap_clk, ap_rst_n            clock, async active-low reset
//   s_valid/s_data/s_ready      input word stream
//   nn_ap_start/nn_data_in_*    frame issue to network
//   nn_ap_ready/nn_ap_idle      network handshake / status
//   nn_data_out_valid/_out      network result frame
//   m_valid/m_data/m_last/ready output word stream
//   in_flight, busy             status
//   err_unexpected              sticky protocol error
module nn_stream_driver #(
  parameter int NUM_DATA_INPUTS   = 2,
  parameter int INPUT_DATA_WIDTH  = 16,
  parameter int NUM_DATA_OUTPUTS  = 1,
  parameter int OUTPUT_DATA_WIDTH = 10,
  parameter int MAX_IN_FLIGHT     = 4,
  localparam int CW = $clog2(MAX_IN_FLIGHT + 1)
) (
  input  logic ap_clk,
  input  logic ap_rst_n,
  input  logic s_valid,
  input  logic [INPUT_DATA_WIDTH-1:0] s_data,
  output logic s_ready,
  output logic nn_ap_start,
  output logic nn_data_in_valid,
  output logic [NUM_DATA_INPUTS-1:0][INPUT_DATA_WIDTH-1:0] nn_data_in,
  input  logic nn_ap_ready,
  input  logic nn_ap_idle,
  input  logic nn_data_out_valid,
  input  logic [NUM_DATA_OUTPUTS-1:0][OUTPUT_DATA_WIDTH-1:0] nn_data_out,
  output logic m_valid,
  output logic [OUTPUT_DATA_WIDTH-1:0] m_data,
  output logic m_last,
  input  logic m_ready,
  output logic [CW-1:0] in_flight,
  output logic busy,
  output logic err_unexpected
);

  localparam int IW = (NUM_DATA_INPUTS > 1) ?
    $clog2(NUM_DATA_INPUTS) : 1;
  localparam int OW = (NUM_DATA_OUTPUTS > 1) ?
    $clog2(NUM_DATA_OUTPUTS) : 1;
  localparam int PW = (MAX_IN_FLIGHT > 1) ?
    $clog2(MAX_IN_FLIGHT) : 1;

  typedef logic [NUM_DATA_OUTPUTS-1:0][OUTPUT_DATA_WIDTH-1:0] frame_t;
  typedef enum logic {P_FILL, P_ISSUE} pstate_t;
  typedef enum logic {S_IDLE, S_SEND} sstate_t;

  // r_live keeps handshake outputs low while reset is held
  logic r_live;
  pstate_t r_pstate, w_pstate_nxt;
  sstate_t r_sstate, w_sstate_nxt;
  logic [IW-1:0] r_in_idx;
  logic [NUM_DATA_INPUTS-1:0][INPUT_DATA_WIDTH-1:0] r_data_in;
  logic [CW-1:0] r_in_flight;
  logic [CW-1:0] r_fifo_cnt;
  logic [CW-1:0] w_cnt_nxt;
  logic [PW-1:0] r_wr_ptr, r_rd_ptr;
  frame_t r_mem [MAX_IN_FLIGHT];
  frame_t w_head;
  logic [OW-1:0] r_out_idx;
  logic r_err;

  logic [CW:0] w_occ;
  logic w_credit_ok;
  logic w_in_last;
  logic w_accept;
  logic w_issue;
  logic w_full;
  logic w_empty;
  logic w_pop;
  logic w_bad;
  logic w_push;
  logic w_dec;
  logic w_out_last;

  // FIFO occupancy is part of the credit, so the FIFO cannot overflow
  assign w_occ = {1'b0, r_in_flight} + {1'b0, r_fifo_cnt};
  assign w_credit_ok = w_occ < (CW+1)'(MAX_IN_FLIGHT);
  assign w_in_last = r_in_idx == IW'(NUM_DATA_INPUTS - 1);
  assign w_accept = s_valid & s_ready;
  assign w_issue = nn_ap_start & nn_ap_ready;

  assign w_full = r_fifo_cnt == CW'(MAX_IN_FLIGHT);
  assign w_empty = r_fifo_cnt == '0;
  assign w_head = r_mem[r_rd_ptr];
  assign w_out_last = r_out_idx == OW'(NUM_DATA_OUTPUTS - 1);

  assign m_valid = r_sstate == S_SEND;
  assign m_last = m_valid & w_out_last;
  assign m_data = m_valid ? w_head[r_out_idx] : '0;

  assign w_pop = m_valid & m_ready & w_out_last;
  assign w_bad = nn_data_out_valid &
    ((r_in_flight == '0) | (w_full & ~w_pop));
  assign w_push = nn_data_out_valid & ~w_bad;
  assign w_dec = nn_data_out_valid & (r_in_flight != '0);
  assign w_cnt_nxt = r_fifo_cnt + CW'(w_push) - CW'(w_pop);

  assign nn_data_in = r_data_in;
  assign nn_data_in_valid = nn_ap_start;
  assign in_flight = r_in_flight;
  assign err_unexpected = r_err;
  assign busy = r_live & ((r_in_flight != '0) | ~w_empty |
    (r_pstate == P_ISSUE) | (r_in_idx != '0) | ~nn_ap_idle);

  always_comb begin
    w_pstate_nxt = r_pstate;
    s_ready = 1'b0;
    nn_ap_start = 1'b0;
    unique case (r_pstate)
      P_FILL: begin
        s_ready = r_live;
        if (r_live && s_valid && w_in_last)
          w_pstate_nxt = P_ISSUE;
      end
      P_ISSUE: begin
        nn_ap_start = w_credit_ok;
        if (w_credit_ok && nn_ap_ready)
          w_pstate_nxt = P_FILL;
      end
      default: w_pstate_nxt = P_FILL;
    endcase
  end

  always_comb begin
    w_sstate_nxt = r_sstate;
    unique case (r_sstate)
      S_IDLE: begin
        if (!w_empty || w_push)
          w_sstate_nxt = S_SEND;
      end
      S_SEND: begin
        if (w_pop && w_cnt_nxt == '0)
          w_sstate_nxt = S_IDLE;
      end
      default: w_sstate_nxt = S_IDLE;
    endcase
  end

  always_ff @(posedge ap_clk or negedge ap_rst_n) begin
    if (!ap_rst_n) begin
      r_live <= 1'b0;
      r_pstate <= P_FILL;
      r_in_idx <= '0;
      r_data_in <= '0;
    end else begin
      r_live <= 1'b1;
      r_pstate <= w_pstate_nxt;
      if (w_accept) begin
        r_data_in[r_in_idx] <= s_data;
        r_in_idx <= w_in_last ? '0 : r_in_idx + 1'b1;
      end
    end
  end

  always_ff @(posedge ap_clk or negedge ap_rst_n) begin
    if (!ap_rst_n) begin
      r_in_flight <= '0;
      r_err <= 1'b0;
    end else begin
      r_in_flight <= r_in_flight + CW'(w_issue) - CW'(w_dec);
      if (w_bad)
        r_err <= 1'b1;
    end
  end

  always_ff @(posedge ap_clk or negedge ap_rst_n) begin
    if (!ap_rst_n) begin
      r_fifo_cnt <= '0;
      r_wr_ptr <= '0;
      r_rd_ptr <= '0;
      for (int i = 0; i < MAX_IN_FLIGHT; i++)
        r_mem[i] <= '0;
    end else begin
      r_fifo_cnt <= w_cnt_nxt;
      if (w_push) begin
        r_mem[r_wr_ptr] <= nn_data_out;
        r_wr_ptr <= (r_wr_ptr == PW'(MAX_IN_FLIGHT - 1)) ?
          '0 : r_wr_ptr + 1'b1;
      end
      if (w_pop)
        r_rd_ptr <= (r_rd_ptr == PW'(MAX_IN_FLIGHT - 1)) ?
          '0 : r_rd_ptr + 1'b1;
    end
  end

  always_ff @(posedge ap_clk or negedge ap_rst_n) begin
    if (!ap_rst_n) begin
      r_sstate <= S_IDLE;
      r_out_idx <= '0;
    end else begin
      r_sstate <= w_sstate_nxt;
      if (m_valid && m_ready)
        r_out_idx <= w_out_last ? '0 : r_out_idx + 1'b1;
    end
  end

endmodule

// File: tb/tb_nn_stream_driver.sv
// tb_nn_stream_driver: directed bench for nn_stream_driver
// (3-word result frames, 2-word input frames, 4 frames of credit).
module tb_nn_stream_driver;

  logic ap_clk = 1'b0;
  logic ap_rst_n = 1'b0;
  logic s_valid = 1'b0;
  logic [15:0] s_data = '0;
  logic s_ready;
  logic nn_ap_start;
  logic nn_data_in_valid;
  logic [1:0][15:0] nn_data_in;
  logic nn_ap_ready = 1'b1;
  logic nn_ap_idle = 1'b1;
  logic nn_data_out_valid = 1'b0;
  logic [2:0][9:0] nn_data_out = '0;
  logic m_valid;
  logic [9:0] m_data;
  logic m_last;
  logic m_ready = 1'b1;
  logic [2:0] in_flight;
  logic busy;
  logic err_unexpected;

  int n_checks = 0;
  int n_err = 0;

  always #5 ap_clk = ~ap_clk;

  nn_stream_driver #(
    .NUM_DATA_INPUTS(2),
    .INPUT_DATA_WIDTH(16),
    .NUM_DATA_OUTPUTS(3),
    .OUTPUT_DATA_WIDTH(10),
    .MAX_IN_FLIGHT(4)
  ) dut (
    .ap_clk(ap_clk),
    .ap_rst_n(ap_rst_n),
    .s_valid(s_valid),
    .s_data(s_data),
    .s_ready(s_ready),
    .nn_ap_start(nn_ap_start),
    .nn_data_in_valid(nn_data_in_valid),
    .nn_data_in(nn_data_in),
    .nn_ap_ready(nn_ap_ready),
    .nn_ap_idle(nn_ap_idle),
    .nn_data_out_valid(nn_data_out_valid),
    .nn_data_out(nn_data_out),
    .m_valid(m_valid),
    .m_data(m_data),
    .m_last(m_last),
    .m_ready(m_ready),
    .in_flight(in_flight),
    .busy(busy),
    .err_unexpected(err_unexpected)
  );

  task automatic chk(input string tag,
                     input logic [31:0] got,
                     input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge ap_clk);
    #1;
  endtask

  task automatic send_word(input logic [15:0] d);
    int n = 0;
    s_valid = 1'b1;
    s_data = d;
    #1;
    while (!s_ready && n < 50) begin
      tick();
      n++;
    end
    if (n == 50) chk("s_ready_timeout", 0, 1);
    tick();
    s_valid = 1'b0;
  endtask

  task automatic result(input int f);
    for (int i = 0; i < 3; i++)
      nn_data_out[i] = rw(f, i);
    nn_data_out_valid = 1'b1;
    tick();
    nn_data_out_valid = 1'b0;
  endtask

  task automatic collect(input string tag,
                         input logic [9:0] d,
                         input logic l);
    int n = 0;
    while (!m_valid && n < 50) begin
      tick();
      n++;
    end
    if (n == 50) chk("m_valid_timeout", 0, 1);
    chk({tag, "_data"}, 32'(m_data), 32'(d));
    chk({tag, "_last"}, 32'(m_last), 32'(l));
    tick();
  endtask

  task automatic collect_frame(input string tag, input int f);
    for (int i = 0; i < 3; i++)
      collect(tag, rw(f, i), i == 2);
  endtask

  function automatic logic [9:0] rw(input int f, input int i);
    return 10'h200 + 10'(f * 16 + i);
  endfunction

  initial begin
    // reset values
    repeat (2) tick();
    chk("rst_s_ready", 32'(s_ready), 0);
    chk("rst_start", 32'(nn_ap_start), 0);
    chk("rst_din_valid", 32'(nn_data_in_valid), 0);
    chk("rst_din", 32'(nn_data_in), 0);
    chk("rst_m_valid", 32'(m_valid), 0);
    chk("rst_m_data", 32'(m_data), 0);
    chk("rst_m_last", 32'(m_last), 0);
    chk("rst_in_flight", 32'(in_flight), 0);
    chk("rst_busy", 32'(busy), 0);
    chk("rst_err", 32'(err_unexpected), 0);
    ap_rst_n = 1'b1;
    tick();
    chk("post_rst_s_ready", 32'(s_ready), 1);

    // single frame
    send_word(16'h0100);
    send_word(16'h0200);
    chk("t1_start", 32'(nn_ap_start), 1);
    chk("t1_din_valid", 32'(nn_data_in_valid), 1);
    chk("t1_din", 32'(nn_data_in), 32'h0200_0100);
    chk("t1_s_ready", 32'(s_ready), 0);
    tick();
    chk("t1_start_off", 32'(nn_ap_start), 0);
    chk("t1_in_flight", 32'(in_flight), 1);
    chk("t1_busy", 32'(busy), 1);
    repeat (3) tick();
    chk("t1_no_m_valid", 32'(m_valid), 0);
    nn_data_out[0] = 10'h155;
    nn_data_out[1] = 10'h2AA;
    nn_data_out[2] = 10'h0F0;
    nn_data_out_valid = 1'b1;
    tick();
    nn_data_out_valid = 1'b0;
    chk("t1_m_valid_lat", 32'(m_valid), 1);
    chk("t1_in_flight0", 32'(in_flight), 0);
    collect("t1_w0", 10'h155, 1'b0);
    collect("t1_w1", 10'h2AA, 1'b0);
    collect("t1_w2", 10'h0F0, 1'b1);
    chk("t1_m_valid_end", 32'(m_valid), 0);

    // network back-pressure
    nn_ap_ready = 1'b0;
    send_word(16'h1111);
    send_word(16'h2222);
    for (int k = 0; k < 5; k++) begin
      chk("bp_start", 32'(nn_ap_start), 1);
      chk("bp_din", 32'(nn_data_in), 32'h2222_1111);
      chk("bp_in_flight", 32'(in_flight), 0);
      tick();
    end
    nn_ap_ready = 1'b1;
    #1;
    chk("bp_start_rdy", 32'(nn_ap_start), 1);
    tick();
    chk("bp_issued", 32'(in_flight), 1);
    chk("bp_s_ready", 32'(s_ready), 1);
    result(9);
    collect_frame("bp", 9);

    // credit limit with output stalled
    m_ready = 1'b0;
    for (int f = 0; f < 4; f++) begin
      send_word(16'(16'h1000 + f * 2));
      send_word(16'(16'h1001 + f * 2));
      chk("cr_start", 32'(nn_ap_start), 1);
      tick();
    end
    chk("cr_in_flight4", 32'(in_flight), 4);
    for (int f = 0; f < 4; f++) result(f);
    chk("cr_in_flight0", 32'(in_flight), 0);
    chk("cr_m_valid", 32'(m_valid), 1);
    send_word(16'h5550);
    send_word(16'h5551);
    for (int k = 0; k < 3; k++) begin
      chk("cr_blocked", 32'(nn_ap_start), 0);
      chk("cr_s_ready", 32'(s_ready), 0);
      chk("cr_din", 32'(nn_data_in), 32'h5551_5550);
      chk("cr_hold", 32'(m_data), 32'(rw(0, 0)));
      tick();
    end
    m_ready = 1'b1;
    collect_frame("cr_f0", 0);
    chk("cr_f4_start", 32'(nn_ap_start), 1);
    m_ready = 1'b0;
    tick();
    chk("cr_f4_issued", 32'(in_flight), 1);
    chk("cr_f5_s_ready", 32'(s_ready), 1);
    send_word(16'h6660);
    send_word(16'h6661);
    chk("cr_f5_blocked", 32'(nn_ap_start), 0);
    m_ready = 1'b1;
    collect("cr_f1", rw(1, 0), 1'b0);
    collect("cr_f1", rw(1, 1), 1'b0);
    for (int i = 0; i < 3; i++)
      nn_data_out[i] = rw(4, i);
    nn_data_out_valid = 1'b1;
    collect("cr_f1", rw(1, 2), 1'b1);
    nn_data_out_valid = 1'b0;
    m_ready = 1'b0;
    chk("cr_pushpop_err", 32'(err_unexpected), 0);
    chk("cr_pushpop_if", 32'(in_flight), 0);
    chk("cr_f5_start", 32'(nn_ap_start), 1);
    chk("cr_f5_din", 32'(nn_data_in), 32'h6661_6660);
    tick();
    chk("cr_f5_issued", 32'(in_flight), 1);
    m_ready = 1'b1;
    collect_frame("cr_f2", 2);
    collect_frame("cr_f3", 3);
    collect_frame("cr_f4", 4);
    chk("cr_drained", 32'(m_valid), 0);
    result(5);
    collect_frame("cr_f5", 5);
    chk("cr_if_end", 32'(in_flight), 0);

    // unexpected result
    nn_data_out_valid = 1'b1;
    tick();
    nn_data_out_valid = 1'b0;
    chk("err_set", 32'(err_unexpected), 1);
    chk("err_no_m_valid", 32'(m_valid), 0);
    chk("err_in_flight", 32'(in_flight), 0);
    repeat (3) tick();
    chk("err_sticky", 32'(err_unexpected), 1);
    chk("err_no_m_valid2", 32'(m_valid), 0);

    // reset mid-operation
    for (int f = 0; f < 2; f++) begin
      send_word(16'h7770);
      send_word(16'h7771);
      tick();
    end
    chk("mr_in_flight", 32'(in_flight), 2);
    send_word(16'hDEAD);
    ap_rst_n = 1'b0;
    #1;
    chk("mr_s_ready", 32'(s_ready), 0);
    chk("mr_in_flight0", 32'(in_flight), 0);
    chk("mr_err", 32'(err_unexpected), 0);
    chk("mr_busy", 32'(busy), 0);
    chk("mr_din", 32'(nn_data_in), 0);
    chk("mr_start", 32'(nn_ap_start), 0);
    tick();
    ap_rst_n = 1'b1;
    tick();
    send_word(16'hAAAA);
    send_word(16'hBBBB);
    chk("mr_fresh_din", 32'(nn_data_in), 32'hBBBB_AAAA);
    chk("mr_fresh_start", 32'(nn_ap_start), 1);
    tick();
    chk("mr_fresh_if", 32'(in_flight), 1);
    result(7);
    collect_frame("mr_f", 7);
    tick();
    chk("idle_busy", 32'(busy), 0);
    nn_ap_idle = 1'b0;
    #1;
    chk("nn_busy", 32'(busy), 1);
    nn_ap_idle = 1'b1;

    $display("Simulation finished: %0d checks, %0d errors",
             n_checks, n_err);
    $finish;
  end

endmodule

// File: doc/nn_stream_driver.md
Name: nn_stream_driver

Overview:
- Initiator-side adapter that drives a generated neural_network top through its ap_start / ap_ready / ap_idle / data_in_valid / data_out_valid interface.
- Packs a narrow valid/ready input word stream into one input frame and issues it to the network.
- The network exposes no output backpressure, so every result frame is captured into a credit-protected frame FIFO.
- Results are serialised onto a valid/ready output word stream with an end-of-frame marker; the block sits between the system-side stream fabric and the network top.

Parameters:
- NUM_DATA_INPUTS, 2, words per input frame (network data_in array size).
- INPUT_DATA_WIDTH, 16, width of each input word.
- NUM_DATA_OUTPUTS, 1, words per result frame (network data_out array size).
- OUTPUT_DATA_WIDTH, 10, width of each output word.
- MAX_IN_FLIGHT, 4, maximum frames issued but not yet drained from the output FIFO; also the FIFO depth in frames. Must be ≥1.

Ports:
- ap_clk  in  1  single clock domain.
- ap_rst_n  in  1  asynchronous, active-low reset.
- s_valid  in  1  input word valid.
- s_data  in  INPUT_DATA_WIDTH  input word; word 0 of a frame first.
- s_ready  out  1  input word accepted when s_valid & s_ready.
- nn_ap_start  out  1  drives network ap_start.
- nn_data_in_valid  out  1  drives network data_in_valid; always equal to nn_ap_start.
- nn_data_in  out  [NUM_DATA_INPUTS] x INPUT_DATA_WIDTH  packed frame to network.
- nn_ap_ready  in  1  network ap_ready; the frame is consumed on nn_ap_start & nn_ap_ready.
- nn_ap_idle  in  1  network ap_idle; status only.
- nn_data_out_valid  in  1  network result valid, one-cycle pulse per frame.
- nn_data_out  in  [NUM_DATA_OUTPUTS] x OUTPUT_DATA_WIDTH  network result frame.
- m_valid  out  1  output word valid.
- m_data  out  OUTPUT_DATA_WIDTH  output word.
- m_last  out  1  high on the final word of a result frame.
- m_ready  in  1  downstream accept.
- in_flight  out  clog2(MAX_IN_FLIGHT+1)  frames issued but not yet returned by the network.
- busy  out  1  in_flight≠0, or FIFO not empty, or frame pending, or nn_ap_idle=0.
- err_unexpected  out  1  sticky protocol error flag.

Behaviour:
- Reset (asynchronous assert, synchronous release):
  - All outputs 0 except nn_data_in, which is 0 and don't-care.
  - in_idx=0, out_idx=0, FIFO empty, packer in FILL, serialiser in IDLE.
  - A reset asserted mid-frame discards partial input frames, FIFO contents and the in_flight count.
- Packer state machine FILL/ISSUE:
  - FILL: s_ready=1. Each accepted word is written to nn_data_in[in_idx] and in_idx increments. On acceptance with in_idx=NUM_DATA_INPUTS-1, in_idx wraps to 0 and the state moves to ISSUE.
  - ISSUE: s_ready=0. nn_ap_start = nn_data_in_valid = credit_ok, where credit_ok = (in_flight + fifo_count) < MAX_IN_FLIGHT.
  - On nn_ap_start & nn_ap_ready the state returns to FILL, giving one bubble cycle before the next word is accepted.
  - nn_data_in is held stable throughout ISSUE.
  - With credit_ok=0, nn_ap_start stays 0 and no frame is lost.
- Credit and in_flight:
  - +1 on issue handshake; -1 on nn_data_out_valid. Both in the same cycle leave it unchanged.
  - The credit check counts FIFO occupancy, so FIFO overflow is impossible for a compliant network.
- Result capture:
  - Every nn_data_out_valid pulse pushes the whole nn_data_out vector into the FIFO in that cycle, regardless of m_ready.
  - A push and a pop in the same cycle are both legal, including when the FIFO is full.
  - nn_data_out_valid with in_flight=0, or with the FIFO full and no pop that cycle: err_unexpected is set sticky (cleared only by reset), the frame is dropped, and in_flight saturates at 0.
- Serialiser state machine IDLE/SEND:
  - IDLE: m_valid=0. Moves to SEND the cycle after the FIFO becomes non-empty (registered output).
  - SEND: m_valid=1, m_data = head[out_idx], m_last = (out_idx==NUM_DATA_OUTPUTS-1).
  - On m_valid & m_ready: out_idx increments. On the last word, the head is popped, out_idx wraps to 0, and the block stays in SEND if the FIFO still holds a frame, else goes to IDLE.
  - m_data and m_last are held stable while m_valid & ~m_ready.
- Latency:
  - Last input word accepted at cycle t gives nn_ap_start at t+1 (if credit_ok).
  - nn_data_out_valid at cycle r gives first m_valid at r+1 (if the FIFO was empty).
- Ordering: output frames are strictly in issue order. Word order within a frame follows index 0 upward.

Test Plan:
- Single frame, defaults, network model latency 9 / II 1: s_data 0x0100 then 0x0200 → nn_data_in={0x0200,0x0100}, nn_ap_start one cycle; result 0x155 → m_data=0x155 with m_last=1 one cycle after nn_data_out_valid; in_flight 1→0.
- Credit limit, MAX_IN_FLIGHT=4, m_ready=0: stream 6 frames → exactly 4 issues; the 5th frame is held in ISSUE with s_ready=0. Raise m_ready → the 5th issues the cycle after the first pop, then the 6th is accepted; all 6 results emerge in order.
- Back-pressure on the network: nn_ap_ready=0 for 5 cycles during ISSUE → nn_ap_start and nn_data_in held stable, in_flight unchanged; issue completes on the first cycle nn_ap_ready=1.
- Multi-word output, NUM_DATA_OUTPUTS=3, m_ready toggling 1,0,1,0: words A,B,C emitted in order, each held while m_ready=0; m_last only on C; simultaneous push/pop at full FIFO gives no error.
- Protocol error: nn_data_out_valid pulse with in_flight=0 → err_unexpected=1 and stays set, no m_valid, in_flight remains 0.
- Reset mid-operation: ap_rst_n low after 1 of 2 input words with 2 frames in flight → all outputs 0 immediately. After release, a fresh 2-word frame produces the correct nn_data_in with no stale word.
